// File: rtl/line_decoder_rr_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 line decoder (Enable, A=MSB, B, C=LSB); optional hold timeout under LINE_ARB_TIMEOUT_EN.
// Latency: one edge from request to Enable; every release is followed by one Enable=0 gap cycle (break-before-make).
module line_decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic       enable_o,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       timeout_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] sel;
  logic [2:0] cand;
  logic       found;
  logic       normal_rel;
  logic       force_rel;

  // Rotating-priority scan starting at the pointer.
  always_comb begin
    sel   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign normal_rel = done_i | ~req_i[idx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = sel;
        end
      end
      GRANT: begin
        if (normal_rel || force_rel) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

`ifdef LINE_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  // Counter sits at zero while idle, so it is cleared on every grant entry.
  assign force_rel = (state_q == GRANT) && !normal_rel && (hold_q == HOLD_LAST);

  always_comb begin
    hold_d    = '0;
    timeout_d = force_rel;
    if (state_q == GRANT) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Elaboration-time guard: an empty block is created only for an illegal width.
  if (2 ** HOLD_W <= MAX_HOLD) begin : g_hold_w_too_small
  end

  assign enable_o = (state_q == GRANT);
  assign a_o      = idx_q[2];
  assign b_o      = idx_q[1];
  assign c_o      = idx_q[0];

endmodule
